rr_lock_arbiter: RTL and testbench

- Registered round-robin arbiter with grant lock for N requesters sharing one resource.
- A requester keeps its grant while it holds req, up to HOLD_MAX cycles under contention. Past that limit the grant is forcibly revoked.
- Replaces the fixed-priority 3-way arbiter wherever fairness and bounded hold time are required.

---
 rtl/rr_lock_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_lock_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: registered round-robin arbiter with a grant lock.
// An owner keeps the resource while requesting, but it is revoked after HOLD_MAX cycles under contention.
module rr_lock_arbiter #(
    parameter int N = 3,
    parameter int HOLD_MAX = 16,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           preempt
);

    localparam int CW = $clog2(HOLD_MAX);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_MAX - 1);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);
    localparam logic [IDW:0]   N_EXT     = (IDW + 1)'(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [IDW-1:0] ptr_r, ptr_s;
    logic [CW-1:0]  hold_cnt_r, hold_cnt_s;
    logic [N-1:0]   grant_r, grant_s;
    logic           grant_valid_r, grant_valid_s;
    logic [IDW-1:0] grant_id_r, grant_id_s;
    logic           preempt_r, preempt_s;

    logic [2*N-1:0] req_dbl_s;
    logic [N-1:0]   req_rot_s;
    logic [IDW-1:0] offset_s;
    logic [IDW:0]   sum_s;
    logic [IDW-1:0] sel_id_s;
    logic [IDW-1:0] ptr_after_s;
    logic           owner_req_s;
    logic           competitor_s;

    // Rotate req so bit 0 is the requester at ptr, then pick the nearest set bit.
    always_comb begin
        req_dbl_s = {req, req} >> ptr_r;
        req_rot_s = req_dbl_s[N-1:0];
        offset_s  = {IDW{1'b0}};
        for (int j = N - 1; j >= 0; j--) begin
            offset_s = req_rot_s[j] ? IDW'(j) : offset_s;
        end
        sum_s    = {1'b0, ptr_r} + {1'b0, offset_s};
        sel_id_s = (sum_s >= N_EXT) ? IDW'(sum_s - N_EXT) : sum_s[IDW-1:0];
    end

    // Owner/competitor view of the request vector and the post-ownership pointer.
    always_comb begin
        owner_req_s  = |(req & grant_r);
        competitor_s = |(req & ~grant_r);
        ptr_after_s  = (grant_id_r == ID_LAST) ? {IDW{1'b0}} : grant_id_r + IDW'(1);
    end

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        grant_s    = grant_r;
        grant_id_s = grant_id_r;
        preempt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    grant_s    = {{(N-1){1'b0}}, 1'b1} << sel_id_s;
                    grant_id_s = sel_id_s;
                    hold_cnt_s = {CW{1'b0}};
                    state_s    = ST_GRANT;
                end else begin
                    grant_s = {N{1'b0}};
                end
            end
            ST_GRANT: begin
                if (!owner_req_s) begin
                    // Release wins over revoke, so no preempt here.
                    grant_s = {N{1'b0}};
                    ptr_s   = ptr_after_s;
                    state_s = ST_GAP;
                end else if ((hold_cnt_r == HOLD_LAST) && competitor_s) begin
                    grant_s   = {N{1'b0}};
                    preempt_s = 1'b1;
                    ptr_s     = ptr_after_s;
                    state_s   = ST_GAP;
                end else begin
                    hold_cnt_s = (hold_cnt_r == HOLD_LAST) ? hold_cnt_r : hold_cnt_r + CW'(1);
                end
            end
            ST_GAP: begin
                grant_s = {N{1'b0}};
                state_s = ST_IDLE;
            end
            default: begin
                grant_s = {N{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
        grant_valid_s = |grant_s;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            ptr_r         <= {IDW{1'b0}};
            hold_cnt_r    <= {CW{1'b0}};
            grant_r       <= {N{1'b0}};
            grant_valid_r <= 1'b0;
            grant_id_r    <= {IDW{1'b0}};
            preempt_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            ptr_r         <= ptr_s;
            hold_cnt_r    <= hold_cnt_s;
            grant_r       <= grant_s;
            grant_valid_r <= grant_valid_s;
            grant_id_r    <= grant_id_s;
            preempt_r     <= preempt_s;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign grant_id    = grant_id_r;
    assign preempt     = preempt_r;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed self-checking bench for rr_lock_arbiter (N=3, HOLD_MAX=4).
module tb_rr_lock_arbiter;

    localparam int N = 3;
    localparam int HOLD_MAX = 4;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           preempt;

    int checks = 0;
    int errors = 0;

    rr_lock_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 3'b000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = 3'b000;
        rst_n = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b000 || grant_valid !== 1'b0 || grant_id !== 2'd0 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got grant=%b valid=%b id=%0d preempt=%b want 000/0/0/0", grant, grant_valid, grant_id, preempt);
        end
        rst_n = 1'b1;
        req   = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b010 || grant_id !== 2'd1 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_grant got grant=%b id=%0d valid=%b want 010/1/1", grant, grant_id, grant_valid);
        end
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 3'b000 || grant_valid !== 1'b0 || grant_id !== 2'd0 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got grant=%b valid=%b id=%0d preempt=%b want 000/0/0/0", grant, grant_valid, grant_id, preempt);
        end
        req   = 3'b111;
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b001 || grant_id !== 2'd0 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL reset_ptr0 got grant=%b id=%0d preempt=%b want 001/0/0", grant, grant_id, preempt);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 3'b001;
        tick();
        checks++;
        if (grant !== 3'b001 || grant_id !== 2'd0 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got grant=%b id=%0d valid=%b want 001/0/1", grant, grant_id, grant_valid);
        end
        req = 3'b000;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (grant !== 3'b000 || grant_valid !== 1'b0 || preempt !== 1'b0) begin
                errors++;
                $display("FAIL single_release[%0d] got grant=%b valid=%b preempt=%b want 000/0/0", c, grant, grant_valid, preempt);
            end
        end
    endtask

    task automatic test_timeout();
        logic [2:0] exp_g [0:18];
        logic       exp_p [0:18];
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
                  3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
                  3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b001};
        exp_p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        req = 3'b111;
        for (int c = 0; c < 19; c++) begin
            tick();
            checks++;
            if (grant !== exp_g[c] || preempt !== exp_p[c] || grant_valid !== (exp_g[c] != 3'b000)) begin
                errors++;
                $display("FAIL timeout[%0d] got grant=%b preempt=%b valid=%b want grant=%b preempt=%b", c, grant, preempt, grant_valid, exp_g[c], exp_p[c]);
            end
            if (exp_g[c] == 3'b010) begin
                checks++;
                if (grant_id !== 2'd1) begin
                    errors++;
                    $display("FAIL timeout_id[%0d] got %0d want 1", c, grant_id);
                end
            end else if (exp_g[c] == 3'b100) begin
                checks++;
                if (grant_id !== 2'd2) begin
                    errors++;
                    $display("FAIL timeout_id[%0d] got %0d want 2", c, grant_id);
                end
            end
        end
    endtask

    task automatic test_no_competitor();
        do_reset();
        req = 3'b010;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (grant !== 3'b010 || preempt !== 1'b0 || grant_id !== 2'd1) begin
                errors++;
                $display("FAIL no_comp[%0d] got grant=%b preempt=%b id=%0d want 010/0/1", c, grant, preempt, grant_id);
            end
        end
    endtask

    task automatic test_wrap_release();
        do_reset();
        req = 3'b100;
        tick();
        req = 3'b101;
        for (int c = 0; c < 3; c++) begin
            tick();
        end
        checks++;
        if (grant !== 3'b100 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL wrap_hold got grant=%b id=%0d want 100/2", grant, grant_id);
        end
        req = 3'b011;
        tick();
        checks++;
        if (grant !== 3'b000 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL wrap_release got grant=%b preempt=%b want 000/0", grant, preempt);
        end
        tick();
        checks++;
        if (grant !== 3'b000 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL wrap_gap got grant=%b preempt=%b want 000/0", grant, preempt);
        end
        tick();
        checks++;
        if (grant !== 3'b001 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL wrap_next got grant=%b id=%0d want 001/0", grant, grant_id);
        end
    endtask

    task automatic test_late_arrival();
        do_reset();
        req = 3'b010;
        tick();
        req = 3'b011;
        tick();
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("FAIL late_hold got grant=%b want 010", grant);
        end
        req = 3'b001;
        tick();
        checks++;
        if (grant !== 3'b000 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL late_release got grant=%b preempt=%b want 000/0", grant, preempt);
        end
        tick();
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("FAIL late_gap got grant=%b want 000", grant);
        end
        tick();
        checks++;
        if (grant !== 3'b001 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL late_next got grant=%b id=%0d want 001/0", grant, grant_id);
        end
    endtask

    task automatic test_rotation_after_release();
        do_reset();
        req = 3'b010;
        tick();
        req = 3'b101;
        tick();
        tick();
        tick();
        checks++;
        if (grant !== 3'b100 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL rotate_next got grant=%b id=%0d want 100/2", grant, grant_id);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        test_reset();
        test_single();
        test_timeout();
        test_no_competitor();
        test_wrap_release();
        test_late_arrival();
        test_rotation_after_release();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
